// File: rtl/mmio_bus_pkg.sv
// Shared types and default address map for the MMIO router slice.
package mmio_bus_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Index 0 = RAM, 1 = LEDs, 2 = switches, 3 = UART
  localparam logic [3:0][31:0] DEF_BASE = {32'h1000_0020, 32'h1000_0010,
                                           32'h1000_0000, 32'h0000_0000};
  localparam logic [3:0][31:0] DEF_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                           32'hFFFF_FFF0, 32'hFFFF_0000};

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmio_bus_if.sv
// Core-side request/response handshake of the MMIO router.
interface mmio_bus_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic              m_done;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;

  modport master (output m_req, m_we, m_addr, m_wdata,
                  input  m_ready, m_done, m_rdata, m_err);

  modport slave  (input  m_req, m_we, m_addr, m_wdata,
                  output m_ready, m_done, m_rdata, m_err);
endinterface

// File: rtl/mmio_addr_decoder.sv
// Combinational base/mask window decode; lowest-index hit wins on overlap.
module mmio_addr_decoder #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [N_SLAVES-1:0] hit,
  output logic                any_hit
);

  always_comb begin
    hit     = '0;
    any_hit = 1'b0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!any_hit && ((addr & SLV_MASK[i]) == SLV_BASE[i])) begin
        hit[i]  = 1'b1;
        any_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_bus_router.sv
// Registered single-outstanding MMIO interconnect with timeout and error logging.
module mmio_bus_router
  import mmio_bus_pkg::*;
#(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_BASE = DEF_BASE,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_MASK = DEF_MASK,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic                       clk,
  input  logic                       rst,
  mmio_bus_if.slave                  bus,
  output logic [N_SLAVES-1:0]        s_sel,
  output logic                       s_we,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [N_SLAVES-1:0]        s_ack,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  output logic [ADDR_W-1:0]          err_addr,
  output logic [7:0]                 err_cnt
);

  state_t              state_q, state_d;
  logic [N_SLAVES-1:0] hit;
  logic                any_hit;
  logic [15:0]         tmo_cnt;
  logic                tmo_hit;
  logic                ack_sel;
  logic [DATA_W-1:0]   sel_rdata;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  mmio_addr_decoder #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr    (bus.m_addr),
    .hit     (hit),
    .any_hit (any_hit)
  );

  // Only the selected slave's ack and data matter; stray acks are masked off.
  assign ack_sel = |(s_ack & s_sel);
  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (s_sel[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.m_req) state_d = any_hit ? BUSY : RESP;
      BUSY:    if (ack_sel || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      s_sel    <= '0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      tmo_cnt  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.m_req) begin
            s_we    <= bus.m_we;
            s_addr  <= bus.m_addr;
            s_wdata <= bus.m_wdata;
            tmo_cnt <= '0;
            if (any_hit) begin
              s_sel <= hit;
            end else begin
              err_q    <= 1'b1;
              rdata_q  <= ERR_DATA;
              err_addr <= bus.m_addr;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          // Ack is tested first so it beats a coincident timeout.
          if (ack_sel) begin
            s_sel   <= '0;
            rdata_q <= s_we ? '0 : sel_rdata;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            s_sel    <= '0;
            rdata_q  <= ERR_DATA;
            err_q    <= 1'b1;
            err_addr <= s_addr;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        RESP:    err_q <= 1'b0;
        default: err_q <= 1'b0;
      endcase
    end
  end

  assign bus.m_ready = (state_q == IDLE);
  assign bus.m_done  = (state_q == RESP);
  assign bus.m_rdata = rdata_q;
  assign bus.m_err   = err_q;

endmodule

// File: tb/tb_mmio_bus_router.sv
// Directed self-checking bench for mmio_bus_router (TIMEOUT=8, default map).
module tb_mmio_bus_router;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_ack;
  logic [127:0] s_rdata;
  logic [31:0]  err_addr;
  logic [7:0]   err_cnt;

  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_chk  = 0;

  mmio_bus_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mmio_bus_router #(
    .N_SLAVES (4),
    .ADDR_W   (32),
    .DATA_W   (32),
    .TIMEOUT  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .s_sel    (s_sel),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ack    (s_ack),
    .s_rdata  (s_rdata),
    .err_addr (err_addr),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.m_req   = 1'b1;
    bus.m_we    = we;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
  endtask

  initial begin
    rst         = 1'b1;
    bus.m_req   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    s_ack       = '0;
    s_rdata     = '0;
    step();
    step();

    // Reset state
    chk("rst_ready", 64'(bus.m_ready), 64'd1);
    chk("rst_done",  64'(bus.m_done),  64'd0);
    chk("rst_err",   64'(bus.m_err),   64'd0);
    chk("rst_rdata", 64'(bus.m_rdata), 64'd0);
    chk("rst_sel",   64'(s_sel),       64'd0);
    chk("rst_ecnt",  64'(err_cnt),     64'd0);
    chk("rst_eaddr", 64'(err_addr),    64'd0);
    rst = 1'b0;
    step();

    // Switch read, same-cycle ack
    request(1'b0, 32'h1000_0010, 32'h0);
    step();
    bus.m_req = 1'b0;
    chk("sw_sel",   64'(s_sel),       64'h4);
    chk("sw_ready", 64'(bus.m_ready), 64'd0);
    chk("sw_addr",  64'(s_addr),      64'h1000_0010);
    chk("sw_done1", 64'(bus.m_done),  64'd0);
    s_ack = 4'b0100;
    s_rdata[64 +: 32] = 32'h0000_00A5;
    step();
    s_ack = '0;
    chk("sw_done",  64'(bus.m_done),  64'd1);
    chk("sw_rdata", 64'(bus.m_rdata), 64'hA5);
    chk("sw_err",   64'(bus.m_err),   64'd0);
    chk("sw_desel", 64'(s_sel),       64'd0);
    step();
    chk("sw_done_pulse", 64'(bus.m_done),  64'd0);
    chk("sw_ready2",     64'(bus.m_ready), 64'd1);

    // RAM write with three wait cycles
    request(1'b1, 32'h0000_0040, 32'h1234_5678);
    step();
    bus.m_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("ram_sel",   64'(s_sel),      64'h1);
      chk("ram_we",    64'(s_we),       64'd1);
      chk("ram_addr",  64'(s_addr),     64'h40);
      chk("ram_wdata", 64'(s_wdata),    64'h1234_5678);
      chk("ram_wait",  64'(bus.m_done), 64'd0);
      step();
    end
    chk("ram_addr4", 64'(s_addr),  64'h40);
    chk("ram_wd4",   64'(s_wdata), 64'h1234_5678);
    s_ack = 4'b0001;
    s_rdata[0 +: 32] = 32'hCAFE_F00D;
    step();
    s_ack = '0;
    chk("ram_done",  64'(bus.m_done),  64'd1);
    chk("ram_err",   64'(bus.m_err),   64'd0);
    chk("ram_rdata", 64'(bus.m_rdata), 64'd0);
    step();

    // Unmapped read
    request(1'b0, 32'h2000_0000, 32'h0);
    step();
    bus.m_req = 1'b0;
    chk("um_done",  64'(bus.m_done),  64'd1);
    chk("um_err",   64'(bus.m_err),   64'd1);
    chk("um_rdata", 64'(bus.m_rdata), 64'hDEAD_BEEF);
    chk("um_eaddr", 64'(err_addr),    64'h2000_0000);
    chk("um_ecnt",  64'(err_cnt),     64'd1);
    chk("um_sel",   64'(s_sel),       64'd0);
    step();
    chk("um_ready", 64'(bus.m_ready), 64'd1);
    chk("um_err2",  64'(bus.m_err),   64'd0);

    // UART never acks: eight cycles selected, then error
    request(1'b0, 32'h1000_0020, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      bus.m_req = 1'b0;
      chk("to_sel",  64'(s_sel),      64'h8);
      chk("to_wait", 64'(bus.m_done), 64'd0);
    end
    step();
    chk("to_desel", 64'(s_sel),       64'd0);
    chk("to_done",  64'(bus.m_done),  64'd1);
    chk("to_err",   64'(bus.m_err),   64'd1);
    chk("to_rdata", 64'(bus.m_rdata), 64'hDEAD_BEEF);
    chk("to_eaddr", 64'(err_addr),    64'h1000_0020);
    chk("to_ecnt",  64'(err_cnt),     64'd2);
    step();

    // Ack in the eighth cycle beats the timeout
    request(1'b0, 32'h1000_0020, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      bus.m_req = 1'b0;
    end
    chk("tack_sel", 64'(s_sel), 64'h8);
    s_ack = 4'b1000;
    s_rdata[96 +: 32] = 32'h0000_0055;
    step();
    s_ack = '0;
    chk("tack_done",  64'(bus.m_done),  64'd1);
    chk("tack_err",   64'(bus.m_err),   64'd0);
    chk("tack_rdata", 64'(bus.m_rdata), 64'h55);
    chk("tack_ecnt",  64'(err_cnt),     64'd2);
    step();

    // Reset while BUSY
    request(1'b1, 32'h0000_0100, 32'hAAAA_5555);
    step();
    bus.m_req = 1'b0;
    chk("rb_sel", 64'(s_sel), 64'h1);
    rst = 1'b1;
    #1;
    chk("rb_sel0",  64'(s_sel),       64'd0);
    chk("rb_ready", 64'(bus.m_ready), 64'd1);
    chk("rb_we",    64'(s_we),        64'd0);
    chk("rb_addr",  64'(s_addr),      64'd0);
    chk("rb_wdata", 64'(s_wdata),     64'd0);
    chk("rb_ecnt",  64'(err_cnt),     64'd0);
    chk("rb_eaddr", 64'(err_addr),    64'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rb_nodone", 64'(bus.m_done), 64'd0);
    end
    request(1'b0, 32'h1000_0000, 32'h0);
    step();
    bus.m_req = 1'b0;
    chk("rb2_sel", 64'(s_sel), 64'h2);
    s_ack = 4'b0010;
    s_rdata[32 +: 32] = 32'h0000_003C;
    step();
    s_ack = '0;
    chk("rb2_done",  64'(bus.m_done),  64'd1);
    chk("rb2_rdata", 64'(bus.m_rdata), 64'h3C);
    chk("rb2_err",   64'(bus.m_err),   64'd0);
    step();

    // Requests during BUSY and a stray ack are ignored
    request(1'b0, 32'h1000_0000, 32'h0);
    step();
    chk("ig_sel", 64'(s_sel), 64'h2);
    request(1'b0, 32'h2000_0000, 32'h0);
    s_ack = 4'b0100;
    s_rdata[64 +: 32] = 32'h0000_0077;
    s_rdata[32 +: 32] = 32'h0000_0099;
    step();
    chk("ig_sel2",  64'(s_sel),      64'h2);
    chk("ig_done2", 64'(bus.m_done), 64'd0);
    step();
    chk("ig_sel3",  64'(s_sel),      64'h2);
    chk("ig_done3", 64'(bus.m_done), 64'd0);
    chk("ig_eaddr", 64'(err_addr),   64'd0);
    bus.m_req = 1'b0;
    s_ack = 4'b0010;
    step();
    s_ack = '0;
    chk("ig_done",  64'(bus.m_done),  64'd1);
    chk("ig_rdata", 64'(bus.m_rdata), 64'h99);
    chk("ig_err",   64'(bus.m_err),   64'd0);
    chk("ig_ecnt",  64'(err_cnt),     64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ig_nodone", 64'(bus.m_done),  64'd0);
      chk("ig_idle",   64'(bus.m_ready), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
